sonar_serial_rx: RTL

//  Receiving end of the sonar serial link: UART receiver plus frame parser for the
//  "AAA,DDD#" records the sonar transmits (angle, distance; 3 ASCII digits each).

---
 rtl/sonar_serial_rx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/sonar_serial_rx.sv
// Sonar link receiver: 7E2 UART plus parser for "AAA,DDD#" records, decoded to BCD.
// Define SONAR_RX_PARITY_EN to reject characters whose even parity does not match.
module sonar_serial_rx #(
  parameter int TICKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        frame_valido,
  output logic        erro_frame,
  output logic        recebendo
);

  localparam int CNT_W = $clog2(TICKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(TICKS_PER_BIT / 2);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    P_D0, P_D1, P_D2, P_COMMA, P_E0, P_E1, P_E2, P_HASH, P_WAIT_HASH
  } p_state_t;

  function automatic logic is_digit(input logic [6:0] c);
    return (c[6:4] == 3'b011) && (c[3:0] <= 4'd9);
  endfunction

  // ---- stage p0/p1: input synchronizer, plus previous value for edge detect
  logic sync_p0, sync_p1, line_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_p0   <= entrada_serial;
      sync_p1   <= sync_p0;
      line_prev <= sync_p1;
    end
  end

  // ---- character receiver
  rx_state_t        rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       shift_q, shift_d;
  logic [6:0]       char_q, char_d;
  logic             stop_bad_q, stop_bad_d;
  logic             char_ok, char_ok_d;
  logic             char_err, char_err_d;
  logic             par_bad;
`ifdef SONAR_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_q       <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      char_q     <= '0;
      stop_bad_q <= 1'b0;
      char_ok    <= 1'b0;
      char_err   <= 1'b0;
`ifdef SONAR_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      char_q     <= char_d;
      stop_bad_q <= stop_bad_d;
      char_ok    <= char_ok_d;
      char_err   <= char_err_d;
`ifdef SONAR_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  always_comb begin
    rx_d       = rx_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    char_d     = char_q;
    stop_bad_d = stop_bad_q;
    char_ok_d  = 1'b0;
    char_err_d = 1'b0;
`ifdef SONAR_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    unique case (rx_q)
      RX_IDLE: begin
        cnt_d      = '0;
        stop_bad_d = 1'b0;
        // a line stuck low after a break never produces a new falling edge
        if (line_prev && !sync_p1) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == MID_TICK) begin
          cnt_d = '0;
          idx_d = '0;
          rx_d  = sync_p1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_TICK) begin
          cnt_d   = '0;
          shift_d = {sync_p1, shift_q[6:1]};
          if (idx_q == 3'd6) rx_d = RX_PARITY;
          else               idx_d = idx_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_q == LAST_TICK) begin
          cnt_d = '0;
          idx_d = '0;
          rx_d  = RX_STOP;
`ifdef SONAR_RX_PARITY_EN
          par_bad_d = ^{shift_q, sync_p1};
`endif
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_TICK) begin
          cnt_d = '0;
          if (idx_q == 3'd0) begin
            idx_d      = 3'd1;
            stop_bad_d = !sync_p1;
          end else begin
            rx_d   = RX_IDLE;
            char_d = shift_q;
            if (stop_bad_q || !sync_p1 || par_bad) char_err_d = 1'b1;
            else                                   char_ok_d  = 1'b1;
          end
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // second stop-bit phase starts mid stop bit 1; its first half still belongs to stop bit 1
  assign recebendo = (rx_q != RX_IDLE) &&
                     !((rx_q == RX_STOP) && (idx_q == 3'd1) && (cnt_q >= HALF_BIT));

  // ---- record parser, one step per received character
  p_state_t    p_q, p_d;
  logic [23:0] shadow_q, shadow_d;
  logic [11:0] ang_d, dist_d;
  logic        fv_d, ef_d, ch_hash, ch_comma, ch_digit, char_fits;

  assign ch_hash  = (char_q == 7'h23);
  assign ch_comma = (char_q == 7'h2C);
  assign ch_digit = is_digit(char_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q          <= P_D0;
      shadow_q     <= '0;
      angulo       <= '0;
      distancia    <= '0;
      frame_valido <= 1'b0;
      erro_frame   <= 1'b0;
    end else begin
      p_q          <= p_d;
      shadow_q     <= shadow_d;
      angulo       <= ang_d;
      distancia    <= dist_d;
      frame_valido <= fv_d;
      erro_frame   <= ef_d;
    end
  end

  always_comb begin
    unique case (p_q)
      P_D0, P_D1, P_D2, P_E0, P_E1, P_E2: char_fits = ch_digit;
      P_COMMA:                            char_fits = ch_comma;
      P_HASH:                             char_fits = ch_hash;
      default:                            char_fits = 1'b0;
    endcase
  end

  always_comb begin
    p_d      = p_q;
    shadow_d = shadow_q;
    ang_d    = angulo;
    dist_d   = distancia;
    fv_d     = 1'b0;
    ef_d     = 1'b0;
    if (char_ok || char_err) begin
      if (p_q == P_WAIT_HASH) begin
        if (char_ok && ch_hash) p_d = P_D0;
      end else if (char_err || !char_fits) begin
        ef_d = 1'b1;
        p_d  = ch_hash ? P_D0 : P_WAIT_HASH;
      end else begin
        unique case (p_q)
          P_D0:    begin shadow_d[23:20] = char_q[3:0]; p_d = P_D1;    end
          P_D1:    begin shadow_d[19:16] = char_q[3:0]; p_d = P_D2;    end
          P_D2:    begin shadow_d[15:12] = char_q[3:0]; p_d = P_COMMA; end
          P_COMMA: p_d = P_E0;
          P_E0:    begin shadow_d[11:8]  = char_q[3:0]; p_d = P_E1;    end
          P_E1:    begin shadow_d[7:4]   = char_q[3:0]; p_d = P_E2;    end
          P_E2:    begin shadow_d[3:0]   = char_q[3:0]; p_d = P_HASH;  end
          P_HASH: begin
            ang_d  = shadow_q[23:12];
            dist_d = shadow_q[11:0];
            fv_d   = 1'b1;
            p_d    = P_D0;
          end
          default: p_d = P_D0;
        endcase
      end
    end
  end

endmodule
